// File: rtl/mux_scan_bist_if.sv
// Bus between the scan/BIST sequencer and its environment: test request and
// word, the mux select/data/output triple, and the scan result signals.
interface mux_scan_bist_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [0:3]       d_in;
    logic [0:1]       mux_s;
    logic [0:3]       mux_d;
    logic             mux_o;
    logic             busy;
    logic             done;
    logic [0:3]       q;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    // Environment side: requests scans, models the mux, observes results.
    modport master (
        output start, d_in, mux_o,
        input  mux_s, mux_d, busy, done, q, err, err_cnt
    );

    // Sequencer side.
    modport slave (
        input  start, d_in, mux_o,
        output mux_s, mux_d, busy, done, q, err, err_cnt
    );
endinterface

// File: rtl/mux_scan_bist.sv
// Built-in self-test sequencer for a 4x1 mux. Latches a test word, drives it
// onto the mux data inputs, walks the select through 0..3 holding each value
// SETTLE cycles, samples mux_o once per select, reassembles the samples into
// q and flags a mismatch. A saturating counter tracks failed scans.
module mux_scan_bist #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_scan_bist_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [1:0]       k_r, k_s;
    logic [3:0]       c_r, c_s;
    logic [0:3]       mux_d_r, mux_d_s;
    logic [0:3]       q_r, q_s;
    logic [0:1]       mux_s_r, mux_s_s;
    logic             err_r, err_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [0:3]       word_s;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        c_s     = c_r;
        mux_d_s = mux_d_r;
        q_s     = q_r;
        err_s   = err_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        word_s  = q_r;
        case (state_r)
            IDLE: begin
                k_s = 2'd0;
                c_s = 4'd0;
                if (bus.start) begin
                    state_s = SCAN;
                    mux_d_s = bus.d_in;
                    q_s     = 4'b0000;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (c_r == SETTLE_LAST) begin
                    c_s      = 4'd0;
                    q_s[k_r] = bus.mux_o;
                    if (k_r == 2'd3) begin
                        // Last sample: k stays at 3 through DONE, no wrap in SCAN.
                        state_s = DONE;
                        done_s  = 1'b1;
                        word_s  = {q_r[0], q_r[1], q_r[2], bus.mux_o};
                        err_s   = (word_s != mux_d_r);
                        if (err_s && (cnt_r != CNT_MAX)) begin
                            cnt_s = cnt_r + CNT_W'(1'b1);
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        k_s = k_r + 2'd1;
                    end
                end else begin
                    c_s = c_r + 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
                k_s     = 2'd0;
                c_s     = 4'd0;
            end
            default: begin
                state_s = IDLE;
                k_s     = 2'd0;
                c_s     = 4'd0;
            end
        endcase
        busy_s  = (state_s != IDLE);
        // mux_s[0] carries weight 1, mux_s[1] weight 2.
        mux_s_s = {k_s[0], k_s[1]};
    end

    // State and registered-output update with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= 2'd0;
            c_r     <= 4'd0;
            mux_d_r <= 4'b0000;
            q_r     <= 4'b0000;
            mux_s_r <= 2'b00;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            c_r     <= c_s;
            mux_d_r <= mux_d_s;
            q_r     <= q_s;
            mux_s_r <= mux_s_s;
            err_r   <= err_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
        end
    end

    assign bus.mux_s   = mux_s_r;
    assign bus.mux_d   = mux_d_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.q       = q_r;
    assign bus.err     = err_r;
    assign bus.err_cnt = cnt_r;
endmodule

// File: tb/tb_mux_scan_bist.sv
// Bench for mux_scan_bist: three instances (SETTLE=1/CNT_W=8, SETTLE=3/CNT_W=8,
// SETTLE=1/CNT_W=2), each fed by a behavioural mux with selectable faults.
// A cycle-offset model predicts every output each cycle; directed tests add
// hand-computed literal expectations.
module tb_mux_scan_bist;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic       start_a [3];
    logic [0:3] d_a     [3];
    int         fault_a [3];

    logic       busy_a [3];
    logic       done_a [3];
    logic       err_a  [3];
    logic [0:3] q_a    [3];
    logic [0:3] md_a   [3];
    logic [0:1] ms_a   [3];
    logic [7:0] cnt_a  [3];

    function automatic int s_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    // Weighted select value: mux_s[0] weight 1, mux_s[1] weight 2.
    function automatic int wsel(input logic [0:1] s);
        return int'(s[0]) + 2 * int'(s[1]);
    endfunction

    // Mux model: f=0 good, f=1 stuck-at-0 at select 2, f=2 inverted output.
    function automatic logic fmux(input logic [0:3] w, input int k, input int f);
        if (f == 1 && k == 2) return 1'b0;
        if (f == 2) return ~w[k];
        return w[k];
    endfunction

    mux_scan_bist_if #(.CNT_W(8)) if0 ();
    mux_scan_bist_if #(.CNT_W(8)) if1 ();
    mux_scan_bist_if #(.CNT_W(2)) if2 ();

    mux_scan_bist #(.SETTLE(1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mux_scan_bist #(.SETTLE(3), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mux_scan_bist #(.SETTLE(1), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start = start_a[0];
    assign if0.d_in  = d_a[0];
    assign if0.mux_o = fmux(if0.mux_d, wsel(if0.mux_s), fault_a[0]);
    assign if1.start = start_a[1];
    assign if1.d_in  = d_a[1];
    assign if1.mux_o = fmux(if1.mux_d, wsel(if1.mux_s), fault_a[1]);
    assign if2.start = start_a[2];
    assign if2.d_in  = d_a[2];
    assign if2.mux_o = fmux(if2.mux_d, wsel(if2.mux_s), fault_a[2]);

    assign busy_a[0] = if0.busy;  assign busy_a[1] = if1.busy;  assign busy_a[2] = if2.busy;
    assign done_a[0] = if0.done;  assign done_a[1] = if1.done;  assign done_a[2] = if2.done;
    assign err_a[0]  = if0.err;   assign err_a[1]  = if1.err;   assign err_a[2]  = if2.err;
    assign q_a[0]    = if0.q;     assign q_a[1]    = if1.q;     assign q_a[2]    = if2.q;
    assign md_a[0]   = if0.mux_d; assign md_a[1]   = if1.mux_d; assign md_a[2]   = if2.mux_d;
    assign ms_a[0]   = if0.mux_s; assign ms_a[1]   = if1.mux_s; assign ms_a[2]   = if2.mux_s;
    assign cnt_a[0]  = if0.err_cnt;
    assign cnt_a[1]  = if1.err_cnt;
    assign cnt_a[2]  = {6'b000000, if2.err_cnt};

    // Cycle counter used to measure spacing between done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model: m_j = cycles since the accepted start edge, -1 when idle.
    int         m_j    [3];
    logic [0:3] m_word [3];
    logic [0:3] m_q    [3];
    logic       m_err  [3];
    int         m_cnt  [3];

    task automatic model_step(input int i, input logic st, input logic [0:3] dw, input logic r);
        int s;
        int S;
        S = s_of(i);
        if (r) begin
            m_j[i] = -1; m_word[i] = 4'b0000; m_q[i] = 4'b0000;
            m_err[i] = 1'b0; m_cnt[i] = 0;
        end else if (m_j[i] >= 0) begin
            m_j[i]++;
            if (m_j[i] == 4 * S + 1) begin
                m_j[i] = -1;
            end else if (m_j[i] % S == 0) begin
                s = m_j[i] / S - 1;
                m_q[i][s] = fmux(m_word[i], s, fault_a[i]);
                if (s == 3) begin
                    m_err[i] = (m_q[i] != m_word[i]);
                    if (m_err[i] && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
                end
            end
        end else if (st) begin
            m_j[i] = 0; m_word[i] = dw; m_q[i] = 4'b0000;
        end
    endtask

    task automatic compare(input int i);
        int S;
        int ek;
        S  = s_of(i);
        ek = (m_j[i] < 0) ? 0 : ((m_j[i] >= 4 * S) ? 3 : m_j[i] / S);
        chk($sformatf("i%0d_busy", i),  32'(busy_a[i]), 32'(m_j[i] >= 0));
        chk($sformatf("i%0d_done", i),  32'(done_a[i]), 32'(m_j[i] == 4 * S));
        chk($sformatf("i%0d_sel", i),   32'(wsel(ms_a[i])), 32'(ek));
        chk($sformatf("i%0d_mux_d", i), 32'(md_a[i]), 32'(m_word[i]));
        chk($sformatf("i%0d_q", i),     32'(q_a[i]), 32'(m_q[i]));
        chk($sformatf("i%0d_err", i),   32'(err_a[i]), 32'(m_err[i]));
        chk($sformatf("i%0d_cnt", i),   32'(cnt_a[i]), 32'(m_cnt[i]));
    endtask

    // Per-cycle model update and comparison, 1 time unit after each edge.
    initial begin : model_proc
        logic       cs [3];
        logic [0:3] cd [3];
        logic       cr;
        for (int i = 0; i < 3; i++) m_j[i] = -1;
        forever begin
            @(posedge clk);
            cr = rst;
            for (int i = 0; i < 3; i++) begin cs[i] = start_a[i]; cd[i] = d_a[i]; end
            #1;
            for (int i = 0; i < 3; i++) begin
                model_step(i, cs[i], cd[i], cr);
                compare(i);
            end
        end
    end

    task automatic wait_done(input int i, input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (done_a[i]) seen = 1'b1;
        end
        chk($sformatf("i%0d_done_timeout", i), 32'(seen), 32'd1);
    endtask

    // One scan with a single-cycle start pulse; d_in is scrambled afterwards.
    task automatic scan(input int i, input logic [0:3] w);
        @(negedge clk); start_a[i] = 1'b1; d_a[i] = w;
        @(negedge clk); start_a[i] = 1'b0; d_a[i] = ~w;
        wait_done(i, 60);
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_busy"},  32'(busy_a[i]), 32'd0);
        chk({tag, "_done"},  32'(done_a[i]), 32'd0);
        chk({tag, "_sel"},   32'(wsel(ms_a[i])), 32'd0);
        chk({tag, "_mux_d"}, 32'(md_a[i]), 32'd0);
        chk({tag, "_q"},     32'(q_a[i]), 32'd0);
        chk({tag, "_err"},   32'(err_a[i]), 32'd0);
        chk({tag, "_cnt"},   32'(cnt_a[i]), 32'd0);
    endtask

    // Directed stimulus with literal expectations.
    initial begin : stim
        int  last;
        bit  seen;
        int  exp6 [5];
        exp6 = '{1, 2, 3, 3, 3};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin start_a[i] = 1'b0; d_a[i] = 4'b0000; fault_a[i] = 0; end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero(i, $sformatf("rst_i%0d", i));
        rst = 1'b0;
        @(negedge clk);

        // Test 1: single scan of 1011, select walks 0..3.
        start_a[0] = 1'b1; d_a[0] = 4'b1011;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk); start_a[0] = 1'b0;
            chk($sformatf("t1_sel_e%0d", e), 32'(wsel(ms_a[0])), 32'(e));
            chk($sformatf("t1_busy_e%0d", e), 32'(busy_a[0]), 32'd1);
        end
        @(negedge clk);
        chk("t1_done", 32'(done_a[0]), 32'd1);
        chk("t1_q",    32'(q_a[0]), 32'h0000000b);
        chk("t1_err",  32'(err_a[0]), 32'd0);
        chk("t1_cnt",  32'(cnt_a[0]), 32'd0);
        @(negedge clk);
        chk("t1_done_off", 32'(done_a[0]), 32'd0);
        @(negedge clk);

        // Test 2: start held high, all 16 words back to back.
        start_a[0] = 1'b1; d_a[0] = 4'b0000;
        last = 0;
        for (int w = 0; w < 16; w++) begin
            wait_done(0, 20);
            if (w > 0) chk($sformatf("t2_spacing_w%0d", w), 32'(cyc - last), 32'd6);
            last = cyc;
            chk($sformatf("t2_q_w%0d", w), 32'(q_a[0]), 32'(w));
            chk($sformatf("t2_err_w%0d", w), 32'(err_a[0]), 32'd0);
            d_a[0] = 4'(w + 1);
            if (w == 15) start_a[0] = 1'b0;
        end
        chk("t2_cnt", 32'(cnt_a[0]), 32'd0);
        @(negedge clk);

        // Test 3: stuck-at-0 at select 2.
        fault_a[0] = 1;
        scan(0, 4'b1111);
        chk("t3_q",   32'(q_a[0]), 32'h0000000d);
        chk("t3_err", 32'(err_a[0]), 32'd1);
        chk("t3_cnt", 32'(cnt_a[0]), 32'd1);
        repeat (3) scan(0, 4'b1111);
        chk("t3_cnt4", 32'(cnt_a[0]), 32'd4);
        fault_a[0] = 0;
        @(negedge clk);

        // Test 5: reset in the middle of a scan discards it.
        @(negedge clk); start_a[0] = 1'b1; d_a[0] = 4'b1111;
        @(negedge clk); start_a[0] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_zero(0, "t5_rst");
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (done_a[0]) seen = 1'b1; end
        chk("t5_no_done", 32'(seen), 32'd0);
        scan(0, 4'b0001);
        chk("t5_q",   32'(q_a[0]), 32'h00000001);
        chk("t5_err", 32'(err_a[0]), 32'd0);

        // Test 4: SETTLE=3, starts at edges 5 and 12 ignored.
        @(negedge clk); start_a[1] = 1'b1; d_a[1] = 4'b0110;
        for (int e = 0; e <= 12; e++) begin
            @(negedge clk);
            start_a[1] = (e == 4 || e == 11);
            chk($sformatf("t4_sel_e%0d", e), 32'(wsel(ms_a[1])), 32'((e < 12) ? e / 3 : 3));
            chk($sformatf("t4_busy_e%0d", e), 32'(busy_a[1]), 32'd1);
            chk($sformatf("t4_done_e%0d", e), 32'(done_a[1]), 32'(e == 12));
        end
        start_a[1] = 1'b0;
        chk("t4_q",   32'(q_a[1]), 32'h00000006);
        chk("t4_err", 32'(err_a[1]), 32'd0);
        @(negedge clk);
        chk("t4_busy_after", 32'(busy_a[1]), 32'd0);
        repeat (4) @(negedge clk);
        chk("t4_still_idle", 32'(busy_a[1]), 32'd0);

        // Test 6: CNT_W=2 with a permanently faulty mux saturates at 3.
        fault_a[2] = 2;
        for (int n = 0; n < 5; n++) begin
            scan(2, 4'(n * 3));
            chk($sformatf("t6_err_n%0d", n), 32'(err_a[2]), 32'd1);
            chk($sformatf("t6_cnt_n%0d", n), 32'(cnt_a[2]), 32'(exp6[n]));
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
